uart_rx_fifo: RTL and testbench
===============================

// Module: uart_rx_fifo
// PURPOSE
//   Receive-side buffer directly downstream of the UART receiver.
//   Captures each byte the UART flags on DATARX/RX_FLAG, together with its ParityError bit.
//   Acknowledges each byte to the UART with a one-cycle Clear_RX_Flag pulse.
//   Queues entries in a FIFO drained by the host through a first-word-fall-through read port.
// PARAMETERS
//   WORD_LENGTH  8  data bits per received word (matches UART WORD_LENGTH)
//   DEPTH        8  FIFO entries; must be a power of two, >= 2
//   ADDR_WIDTH   3  log2(DEPTH)
// PORTS
//   clk            in   1              system clock, rising edge
//   reset          in   1              asynchronous, active-high
//   DATARX         in   WORD_LENGTH    received word from UART
//   RX_FLAG        in   1              UART: word valid, held until cleared
//   ParityError    in   1              UART parity flag for DATARX
//   Clear_RX_Flag  out  1              one-cycle acknowledge pulse to UART
//   rd_en          in   1              host pop request
//   rd_data        out  WORD_LENGTH    head entry data (valid when !empty)
//   rd_parity_err  out  1              head entry parity flag
//   empty          out  1              FIFO holds 0 entries
//   full           out  1              FIFO holds DEPTH entries
//   count          out  ADDR_WIDTH+1   entries held, 0..DEPTH
//   overrun        out  1              sticky: word dropped because FIFO was full
//   clear_overrun  in   1              synchronous clear of overrun
// BEHAVIOUR
//   Reset (async, active-high), all outputs:
//     Clear_RX_Flag=0, count=0, empty=1, full=0, overrun=0, rd_data=0, rd_parity_err=0
//     Pointers=0, FSM=IDLE.
//   Capture FSM, two states:
//     IDLE: on an edge with RX_FLAG=1:
//       - if !full: write {ParityError,DATARX} at wr_ptr; else set overrun
//       - Clear_RX_Flag=1 for the next cycle exactly; go to WAIT_CLR
//     WAIT_CLR: Clear_RX_Flag=0; return to IDLE on the first edge with RX_FLAG=0.
//       Stays in WAIT_CLR while RX_FLAG=1, so one flag assertion gives exactly one write.
//   Entry storage: each entry is WORD_LENGTH+1 bits, {parity_err, data}.
//   Read port (first-word-fall-through):
//     - rd_data/rd_parity_err reflect mem[rd_ptr] combinationally; 0 when empty.
//     - Pop on an edge with rd_en=1 and !empty: rd_ptr advances.
//     - rd_en while empty is ignored: no pointer or count change, no error.
//   Pointers: ADDR_WIDTH bits, wrap modulo DEPTH (DEPTH-1 -> 0).
//   count update per edge: +1 on write only, -1 on pop only, unchanged on both.
//   Flags: full = (count==DEPTH); empty = (count==0).
//   Simultaneous capture and pop while full:
//     - fullness is judged on pre-edge count, so the write is dropped and overrun sets
//     - the pop still completes and count becomes DEPTH-1
//   Simultaneous capture and pop while count==1: both happen; count stays 1, head advances.
//   overrun: set on a dropped write; cleared by clear_overrun=1; set wins if both in the same cycle.
//   Latency: RX_FLAG high at edge N -> entry visible (empty=0) and Clear_RX_Flag=1 after edge N.
//   Reset mid-operation:
//     - contents are discarded and the FSM returns to IDLE
//     - if RX_FLAG is still high after reset release, that word is captured as new
// TESTING
//   1. Reset, then one word 0x32, PE=0 -> Clear_RX_Flag one-cycle pulse; count=1, rd_data=0x32.
//      Then rd_en 1 cycle -> empty=1.
//   2. RX_FLAG held high 10 cycles, DATARX=0xA5 -> exactly one write (count=1), one Clear_RX_Flag pulse.
//   3. Nine words 0x01..0x09, DEPTH=8, no reads -> full=1 after 8; 0x09 dropped; overrun=1.
//      Then drain 8 pops -> 0x01..0x08 in order.
//   4. Word 0x99 with ParityError=1, then 0x66 with PE=0 -> head shows 0x99/rd_parity_err=1.
//      After pop -> 0x66/0.
//   5. 20 words with a pop each cycle after the first -> pointer wrap: output order 0..19, count<=1, overrun=0.
//   6. Assert reset with count=5 and in WAIT_CLR -> count=0, empty=1, Clear_RX_Flag=0.
//      RX_FLAG=1 after release -> captured.

Source files
------------

// File: rtl/uart_rx_fifo_if.sv
// Bundle of the UART-side capture handshake and the host-side FWFT read port
// of the receive FIFO. The master side is whoever feeds the FIFO and drains it
// (UART plus host); the slave side is the FIFO itself.
interface uart_rx_fifo_if #(
    parameter int WORD_LENGTH = 8,
    parameter int ADDR_WIDTH  = 3
);
    logic [WORD_LENGTH-1:0] DATARX;
    logic                   RX_FLAG;
    logic                   ParityError;
    logic                   Clear_RX_Flag;
    logic                   rd_en;
    logic [WORD_LENGTH-1:0] rd_data;
    logic                   rd_parity_err;
    logic                   empty;
    logic                   full;
    logic [ADDR_WIDTH:0]    count;
    logic                   overrun;
    logic                   clear_overrun;

    modport master (
        output DATARX, RX_FLAG, ParityError, rd_en, clear_overrun,
        input  Clear_RX_Flag, rd_data, rd_parity_err, empty, full, count, overrun
    );

    modport slave (
        input  DATARX, RX_FLAG, ParityError, rd_en, clear_overrun,
        output Clear_RX_Flag, rd_data, rd_parity_err, empty, full, count, overrun
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// Receive-side buffer behind the UART receiver. Captures one word per RX_FLAG
// assertion together with its parity flag, acknowledges it with a one-cycle
// Clear_RX_Flag pulse, and queues it for the host behind a first-word-fall-
// through read port. Words arriving while full are dropped and flagged in a
// sticky overrun bit.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for RX_FLAG; the first edge with it high captures
// WAIT_CLR | word taken, waiting for the UART to drop RX_FLAG
module uart_rx_fifo #(
    parameter int WORD_LENGTH = 8,
    parameter int DEPTH       = 8,
    parameter int ADDR_WIDTH  = 3
) (
    input logic              clk,
    input logic              reset,
    uart_rx_fifo_if.slave    bus
);
    typedef enum logic {IDLE, WAIT_CLR} state_t;

    localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH + 1)'(DEPTH);

    state_t                  state_q, state_d;
    logic                    capture;
    logic                    wr;
    logic                    pop;
    logic                    clr_q;
    logic                    overrun_q;
    logic [ADDR_WIDTH-1:0]   wr_ptr, rd_ptr;
    logic [ADDR_WIDTH:0]     count_q;
    logic [WORD_LENGTH:0]    mem [DEPTH];
    logic [WORD_LENGTH:0]    head;
    logic                    is_full, is_empty;

    assign is_full  = (count_q == DEPTH_C);
    assign is_empty = (count_q == '0);
    // Fullness is judged on the pre-edge count, so a pop in the same cycle
    // does not make room for the incoming word.
    assign wr       = capture && !is_full;
    assign pop      = bus.rd_en && !is_empty;

    // Capture FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next state: one capture per RX_FLAG assertion, however long it is held.
    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.RX_FLAG) begin
                    capture = 1'b1;
                    state_d = WAIT_CLR;
                end
            end
            WAIT_CLR: begin
                if (!bus.RX_FLAG) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Acknowledge pulse in the cycle after the capture edge, plus sticky overrun.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clr_q     <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            clr_q <= capture;
            if (capture && is_full)     overrun_q <= 1'b1;
            else if (bus.clear_overrun) overrun_q <= 1'b0;
        end
    end

    // Pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (wr)  wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            case ({wr, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Entry storage; contents need no reset since the read port masks when empty.
    always_ff @(posedge clk) begin
        if (wr) mem[wr_ptr] <= {bus.ParityError, bus.DATARX};
    end

    assign head              = mem[rd_ptr];
    assign bus.rd_data       = is_empty ? '0 : head[WORD_LENGTH-1:0];
    assign bus.rd_parity_err = is_empty ? 1'b0 : head[WORD_LENGTH];
    assign bus.Clear_RX_Flag = clr_q;
    assign bus.empty         = is_empty;
    assign bus.full          = is_full;
    assign bus.count         = count_q;
    assign bus.overrun       = overrun_q;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: directed scenarios plus a randomized phase, all
// checked every cycle against a queue-based model of the receive buffer.
module tb_uart_rx_fifo;
    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    uart_rx_fifo_if #(.WORD_LENGTH(8), .ADDR_WIDTH(3)) bus ();

    uart_rx_fifo #(.WORD_LENGTH(8), .DEPTH(8), .ADDR_WIDTH(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int         total = 0;
    int         bad   = 0;
    logic [8:0] q[$];
    logic       m_ovr;
    logic       m_clr;
    logic       m_armed;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [8:0] head;
        head = (q.size() > 0) ? q[0] : 9'h0;
        check({tag, ".clr"},     32'(bus.Clear_RX_Flag), 32'(m_clr));
        check({tag, ".count"},   32'(bus.count),         32'(q.size()));
        check({tag, ".empty"},   32'(bus.empty),         32'(q.size() == 0));
        check({tag, ".full"},    32'(bus.full),          32'(q.size() == 8));
        check({tag, ".overrun"}, 32'(bus.overrun),       32'(m_ovr));
        check({tag, ".rd_data"}, 32'(bus.rd_data),       32'(head[7:0]));
        check({tag, ".rd_pe"},   32'(bus.rd_parity_err), 32'(head[8]));
    endtask

    // One clock: drive inputs, predict from pre-edge model state, check after edge.
    task automatic step(input string tag, input logic f, input logic [7:0] d,
                        input logic pe, input logic rd, input logic co);
        bit cap, pop, was_full;
        bus.RX_FLAG       = f;
        bus.DATARX        = d;
        bus.ParityError   = pe;
        bus.rd_en         = rd;
        bus.clear_overrun = co;
        cap      = f && m_armed;
        was_full = (q.size() == 8);
        pop      = rd && (q.size() != 0);
        @(posedge clk);
        #1;
        if (pop) void'(q.pop_front());
        if (cap && !was_full) q.push_back({pe, d});
        if (cap && was_full) m_ovr = 1'b1;
        else if (co)         m_ovr = 1'b0;
        m_clr   = cap;
        m_armed = !f;
        check_all(tag);
    endtask

    // Asynchronous reset asserted away from the edge, inputs left as they are.
    task automatic do_reset(input string tag);
        reset = 1'b1;
        #2;
        q.delete();
        m_ovr   = 1'b0;
        m_clr   = 1'b0;
        m_armed = 1'b1;
        check_all(tag);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        reset             = 1'b1;
        bus.RX_FLAG       = 1'b0;
        bus.DATARX        = '0;
        bus.ParityError   = 1'b0;
        bus.rd_en         = 1'b0;
        bus.clear_overrun = 1'b0;
        #1;
        do_reset("reset");

        // 1: single word, pulse, pop
        step("t1_cap",  1'b1, 8'h32, 1'b0, 1'b0, 1'b0);
        step("t1_drop", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        step("t1_pop",  1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        step("t1_idle", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

        // 2: flag held for 10 cycles gives one write
        repeat (10) step("t2_hold", 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
        step("t2_low", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        step("t2_pop", 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

        // 3: overflow by one, then drain and an ignored pop on empty
        for (int i = 1; i <= 9; i++) begin
            step("t3_fill", 1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
            step("t3_gap",  1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        end
        for (int i = 0; i < 9; i++) step("t3_drain", 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        step("t3_clrovr", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

        // 4: parity flag travels with its word
        step("t4_w99", 1'b1, 8'h99, 1'b1, 1'b0, 1'b0);
        step("t4_gap", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        step("t4_w66", 1'b1, 8'h66, 1'b0, 1'b0, 1'b0);
        step("t4_gap", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        step("t4_pop", 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        step("t4_pop", 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

        // 5: streaming with pops every cycle, pointers wrap several times
        for (int i = 0; i < 20; i++) begin
            step("t5_word", 1'b1, 8'(i), 1'($urandom_range(0, 1)), i != 0, 1'b0);
            step("t5_gap",  1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        end

        // Randomized traffic, including fills, overruns and overrun clears
        for (int i = 0; i < 400; i++) begin
            step("rnd", $urandom_range(0, 2) != 0, 8'($urandom), 1'($urandom_range(0, 1)),
                 $urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0);
        end

        // 6: reset with count=5 while waiting for the flag to drop
        do_reset("t6_pre");
        for (int i = 0; i < 4; i++) begin
            step("t6_fill", 1'b1, 8'h40 + 8'(i), 1'b0, 1'b0, 1'b0);
            step("t6_gap",  1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        end
        step("t6_w5",   1'b1, 8'h44, 1'b0, 1'b0, 1'b0);
        step("t6_hold", 1'b1, 8'h44, 1'b0, 1'b0, 1'b0);
        do_reset("t6_reset");
        step("t6_recap", 1'b1, 8'h5A, 1'b1, 1'b0, 1'b0);
        step("t6_low",   1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        step("t6_pop",   1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
